verificar_senha_param: RTL and testbench

Parametrised PIN verifier for the door-lock datapath: captures an assembled PIN on the rising edge of its status flag, scans it sequentially against a factory/master PIN and a configurable table of user PINs, and issues one-cycle result pulses. Sits between `montar_pin` and the lock-control FSM. It generalises digit count and user-slot count, reports the matched slot index, and adds an optional failed-attempt lockout.

---
 rtl/verificar_senha_param_if.sv | 44 ++++
 rtl/verificar_senha_param.sv | 196 +++++++++++++++++++
 tb/tb_verificar_senha_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/verificar_senha_param_if.sv
// Bundle of the PIN-check request inputs and result outputs of verificar_senha_param.
// Latency: none; this is wiring only.
// Backpressure: none; the checker drops requests while busy.
interface verificar_senha_param_if #(
  parameter int NUM_PINS   = 4,
  parameter int PIN_DIGITS = 4,
  parameter int MAX_FAILS  = 3
);
  localparam int PW = 4 * PIN_DIGITS;
  localparam int IW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);

  // request side
  logic                   pin_valid;
  logic [PW-1:0]          pin_digits;
  logic [PW-1:0]          master_pin;
  logic                   master_valid;
  logic [NUM_PINS*PW-1:0] user_pins;
  logic [NUM_PINS-1:0]    user_en;

  // result side
  logic                   busy;
  logic                   senha_fail;
  logic                   senha_padrao;
  logic                   senha_master;
  logic                   senha_master_update;
  logic [IW-1:0]          match_idx;
  logic                   locked;
  logic [FW-1:0]          fail_count;

  // requester / lock-control side
  modport master (
    output pin_valid, pin_digits, master_pin, master_valid, user_pins, user_en,
    input  busy, senha_fail, senha_padrao, senha_master, senha_master_update,
           match_idx, locked, fail_count
  );

  // checker side
  modport slave (
    input  pin_valid, pin_digits, master_pin, master_valid, user_pins, user_en,
    output busy, senha_fail, senha_padrao, senha_master, senha_master_update,
           match_idx, locked, fail_count
  );
endinterface

// File: rtl/verificar_senha_param.sv
// PIN verifier: latches the PIN on a pin_valid rising edge, checks master/factory PIN, then scans user slots.
// Latency: 1 cycle (invalid, factory mode, master hit), 2+k for user slot k, 1+NUM_PINS for a full miss.
// Backpressure: none; starts seen while busy or locked are dropped. Optional lockout: define PIN_LOCKOUT_EN.
module verificar_senha_param #(
  parameter int                      NUM_PINS       = 4,
  parameter int                      PIN_DIGITS     = 4,
  parameter logic [4*PIN_DIGITS-1:0] FACTORY_PIN    = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  verificar_senha_param_if.slave bus
);
  localparam int PW = 4 * PIN_DIGITS;
  localparam int IW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PINS - 1);

  // Reject out-of-range configurations at elaboration time.
  if (NUM_PINS < 1 || NUM_PINS > 16 || PIN_DIGITS < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("verificar_senha_param: parameter out of range");
  end

`ifdef PIN_LOCKOUT_EN
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCAN_MASTER = 2'd1,
    SCAN_USER   = 2'd2,
    LOCKED      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCAN_MASTER = 2'd1,
    SCAN_USER   = 2'd2
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          pin_valid_q;
  logic [PW-1:0] pin_q, pin_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] match_idx_q, match_idx_d;
  logic          fail_q, fail_d;
  logic          padrao_q, padrao_d;
  logic          master_q, master_d;
  logic          update_q, update_d;
`ifdef PIN_LOCKOUT_EN
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  logic          start;
  logic          digits_ok;
  logic [PW-1:0] user_slot;

  // pin_valid_q resets high so a level already present at reset release is not a start.
  assign start     = bus.pin_valid & ~pin_valid_q;
  assign user_slot = bus.user_pins[int'(idx_q)*PW +: PW];

  // Every captured digit must be BCD 0..9; the blank code 4'hE is rejected here.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < PIN_DIGITS; i++) begin
      if (pin_q[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  // State, captured PIN, scan index and registered result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pin_valid_q <= 1'b1;
      pin_q       <= {PIN_DIGITS{4'hE}};
      idx_q       <= '0;
      match_idx_q <= '0;
      fail_q      <= 1'b0;
      padrao_q    <= 1'b0;
      master_q    <= 1'b0;
      update_q    <= 1'b0;
`ifdef PIN_LOCKOUT_EN
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pin_valid_q <= bus.pin_valid;
      pin_q       <= pin_d;
      idx_q       <= idx_d;
      match_idx_q <= match_idx_d;
      fail_q      <= fail_d;
      padrao_q    <= padrao_d;
      master_q    <= master_d;
      update_q    <= update_d;
`ifdef PIN_LOCKOUT_EN
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  // Next-state and result decode; master/user tables are compared live, only the entered PIN is held.
  always_comb begin
    state_d     = state_q;
    pin_d       = pin_q;
    idx_d       = idx_q;
    match_idx_d = match_idx_q;
    fail_d      = 1'b0;
    padrao_d    = 1'b0;
    master_d    = 1'b0;
    update_d    = 1'b0;
`ifdef PIN_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pin_d   = bus.pin_digits;
          state_d = SCAN_MASTER;
        end
      end
      SCAN_MASTER: begin
        if (!digits_ok) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else if (!bus.master_valid) begin
          // Factory mode: only the factory PIN is accepted, user slots are never scanned.
          if (pin_q == FACTORY_PIN) update_d = 1'b1;
          else                      fail_d   = 1'b1;
          state_d = IDLE;
        end else if (pin_q == bus.master_pin) begin
          master_d = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d   = '0;
          state_d = SCAN_USER;
        end
      end
      SCAN_USER: begin
        // Ascending scan, so the lowest enabled matching slot wins.
        if (bus.user_en[idx_q] && (pin_q == user_slot)) begin
          padrao_d    = 1'b1;
          match_idx_d = idx_q;
          state_d     = IDLE;
        end else if (idx_q == LAST_IDX) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef PIN_LOCKOUT_EN
      LOCKED: begin
        if (lock_cnt_q == '0) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef PIN_LOCKOUT_EN
    // Consecutive-fail accounting; the fail that reaches MAX_FAILS diverts to LOCKED.
    if (fail_d) begin
      if (fail_cnt_q >= FW'(MAX_FAILS - 1)) begin
        fail_cnt_d = FW'(MAX_FAILS);
        lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
        state_d    = LOCKED;
      end else begin
        fail_cnt_d = fail_cnt_q + FW'(1);
      end
    end else if (padrao_d || master_d || update_d) begin
      fail_cnt_d = '0;
    end
`endif
  end

  assign bus.busy                = (state_q != IDLE);
  assign bus.senha_fail          = fail_q;
  assign bus.senha_padrao        = padrao_q;
  assign bus.senha_master        = master_q;
  assign bus.senha_master_update = update_q;
  assign bus.match_idx           = match_idx_q;
`ifdef PIN_LOCKOUT_EN
  assign bus.locked              = (state_q == LOCKED);
  assign bus.fail_count          = fail_cnt_q;
`else
  assign bus.locked              = 1'b0;
  assign bus.fail_count          = '0;
`endif
endmodule

// File: tb/tb_verificar_senha_param.sv
// Bench for verificar_senha_param: expected result pulses are queued at stimulus time
// and matched (kind, cycle, slot) by a monitor when the DUT pulses.
`timescale 1ns/1ps
module tb_verificar_senha_param;
  localparam int NUM_PINS = 4;
  localparam int PIN_DIGITS = 4;
  localparam int MAX_FAILS = 3;
  localparam int LOCKOUT_CYCLES = 30;
  localparam logic [3:0] K_UPD  = 4'b0001;
  localparam logic [3:0] K_MST  = 4'b0010;
  localparam logic [3:0] K_PAD  = 4'b0100;
  localparam logic [3:0] K_FAIL = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    logic [1:0] idx;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lock_run = 0;

  verificar_senha_param_if #(.NUM_PINS(NUM_PINS), .PIN_DIGITS(PIN_DIGITS), .MAX_FAILS(MAX_FAILS)) bus ();

  verificar_senha_param #(
    .NUM_PINS(NUM_PINS), .PIN_DIGITS(PIN_DIGITS), .FACTORY_PIN(16'h1234),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [3:0] p;
    exp_t e;
    p = {bus.senha_fail, bus.senha_padrao, bus.senha_master, bus.senha_master_update};
    if (bus.locked === 1'b1) lock_run++;
    if (p !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: pulses=%b at cycle %0d, required none", p, cyc);
      end else begin
        e = exp_q.pop_front();
        if (p !== e.kind || cyc != e.due || (e.kind == K_PAD && bus.match_idx !== e.idx)) begin
          errors++;
          $display("FAIL result: got pulses=%b cycle=%0d idx=%0d, required pulses=%b cycle=%0d idx=%0d",
                   p, cyc, bus.match_idx, e.kind, e.due, e.idx);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pin_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge with pin_valid low; raises it for one cycle and queues the result.
  task automatic start_pin(input logic [15:0] pin, input logic [3:0] kind, input logic [1:0] idx, input int lat);
    exp_t e;
    bus.pin_digits = pin;
    e.kind = kind;
    e.idx  = idx;
    e.due  = cyc + 1 + lat;
    exp_q.push_back(e);
    bus.pin_valid = 1'b1;
    @(negedge clk);
    bus.pin_valid = 1'b0;
  endtask

  task automatic wait_results(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pin_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.senha_fail, bus.senha_padrao, bus.senha_master, bus.senha_master_update} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b, required 0000",
        {bus.senha_fail, bus.senha_padrao, bus.senha_master, bus.senha_master_update});
    end
    checks++;
    if ({bus.busy, bus.locked} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_locked: got %b, required 00", {bus.busy, bus.locked});
    end
    checks++;
    if (bus.fail_count !== 2'd0 || bus.match_idx !== 2'd0) begin
      errors++; $display("FAIL reset_counts: fail_count=%0d match_idx=%0d, required 0 0", bus.fail_count, bus.match_idx);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_factory();
    do_reset();
    bus.master_valid = 1'b0;
    bus.master_pin = 16'h9876;
    start_pin(16'h1234, K_UPD, 2'd0, 1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL factory_busy: got %b, required 1", bus.busy);
    end
    wait_results("factory_ok");
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL factory_idle: busy=%b, required 0", bus.busy);
    end
    // master_pin is ignored in factory mode
    start_pin(16'h9876, K_FAIL, 2'd0, 1);
    wait_results("factory_wrong");
  endtask

  task automatic test_master_and_user();
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.user_pins = {16'h7777, 16'h5555, 16'h2222, 16'h1111};
    bus.user_en = 4'b1111;
    start_pin(16'h9876, K_MST, 2'd0, 1);
    wait_results("master_match");
    start_pin(16'h5555, K_PAD, 2'd2, 4);
    wait_results("user_slot2");
    bus.user_en = 4'b1011;
    start_pin(16'h5555, K_FAIL, 2'd0, 5);
    wait_results("user_disabled");
    checks++;
    if (bus.match_idx !== 2'd2) begin
      errors++; $display("FAIL match_idx_hold: got %0d, required 2", bus.match_idx);
    end
    bus.user_en = 4'b1111;
    start_pin(16'h1111, K_PAD, 2'd0, 2);
    wait_results("user_slot0");
    bus.user_pins = {16'h4321, 16'h5555, 16'h4321, 16'h1111};
    start_pin(16'h4321, K_PAD, 2'd1, 3);
    wait_results("lowest_slot");
    bus.user_pins = {16'h8888, 16'h5555, 16'h2222, 16'h1111};
    start_pin(16'h8888, K_PAD, 2'd3, 5);
    wait_results("last_slot");
  endtask

  task automatic test_invalid();
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h12E4;
    bus.user_pins = {16'h12E4, 16'h12E4, 16'h12E4, 16'h12E4};
    bus.user_en = 4'b1111;
    start_pin(16'h12E4, K_FAIL, 2'd0, 1);
    wait_results("invalid_digit");
    start_pin(16'hEEEE, K_FAIL, 2'd0, 1);
    wait_results("blank_pin");
  endtask

  task automatic test_ignored_edge();
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.user_pins = {16'h7777, 16'h5555, 16'h2222, 16'h1111};
    bus.user_en = 4'b1111;
    start_pin(16'h0000, K_FAIL, 2'd0, 5);
    @(negedge clk);
    bus.pin_digits = 16'h9876;
    bus.pin_valid = 1'b1;
    @(negedge clk);
    bus.pin_valid = 1'b0;
    wait_results("ignored_edge");
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    e.kind = K_MST; e.idx = 2'd0; e.due = cyc + 2;
    exp_q.push_back(e);
    bus.pin_digits = 16'h9876;
    bus.pin_valid = 1'b1;
    @(negedge clk);
    bus.pin_valid = 1'b0;
    @(negedge clk);
    e.kind = K_FAIL; e.idx = 2'd0; e.due = cyc + 2;
    exp_q.push_back(e);
    bus.pin_digits = 16'hEEEE;
    bus.pin_valid = 1'b1;
    @(negedge clk);
    bus.pin_valid = 1'b0;
    wait_results("back_to_back");
  endtask

`ifdef PIN_LOCKOUT_EN
  task automatic test_lockout();
    int n = 0;
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.user_pins = {16'h7777, 16'h5555, 16'h2222, 16'h1111};
    bus.user_en = 4'b1111;
    for (int i = 1; i <= 2; i++) begin
      start_pin(16'h0000, K_FAIL, 2'd0, 5);
      wait_results("pre_fail");
      checks++;
      if (bus.fail_count !== 2'(i)) begin
        errors++; $display("FAIL fail_count_step: got %0d, required %0d", bus.fail_count, i);
      end
    end
    start_pin(16'h9876, K_MST, 2'd0, 1);
    wait_results("success_clears");
    checks++;
    if (bus.fail_count !== 2'd0) begin
      errors++; $display("FAIL fail_count_clear: got %0d, required 0", bus.fail_count);
    end
    for (int i = 0; i < 2; i++) begin
      start_pin(16'h0000, K_FAIL, 2'd0, 5);
      wait_results("fail_again");
    end
    lock_run = 0;
    start_pin(16'h0000, K_FAIL, 2'd0, 5);
    wait_results("third_fail");
    checks++;
    if (bus.locked !== 1'b1 || bus.busy !== 1'b1 || bus.fail_count !== 2'd3) begin
      errors++; $display("FAIL lock_entry: locked=%b busy=%b fail_count=%0d, required 1 1 3",
                         bus.locked, bus.busy, bus.fail_count);
    end
    bus.pin_digits = 16'h9876;
    bus.pin_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.pin_valid = 1'b0;
    while (bus.locked === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lock_run != LOCKOUT_CYCLES) begin
      errors++; $display("FAIL lock_length: got %0d cycles, required %0d", lock_run, LOCKOUT_CYCLES);
    end
    checks++;
    if (bus.fail_count !== 2'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL lock_exit: fail_count=%0d busy=%b, required 0 0", bus.fail_count, bus.busy);
    end
    start_pin(16'h9876, K_MST, 2'd0, 1);
    wait_results("after_lock");
  endtask
`else
  task automatic test_no_lockout();
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.user_en = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      start_pin(16'h0000, K_FAIL, 2'd0, 5);
      wait_results("repeat_fail");
    end
    checks++;
    if (bus.locked !== 1'b0 || bus.fail_count !== 2'd0) begin
      errors++; $display("FAIL no_lockout: locked=%b fail_count=%0d, required 0 0", bus.locked, bus.fail_count);
    end
    start_pin(16'h9876, K_MST, 2'd0, 1);
    wait_results("after_fails");
  endtask
`endif

  task automatic test_reset_mid_scan();
    do_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.user_pins = {16'h7777, 16'h5555, 16'h2222, 16'h1111};
    bus.user_en = 4'b1111;
    start_pin(16'h5555, K_PAD, 2'd2, 4);
    wait_results("pre_reset_match");
    start_pin(16'h0000, K_FAIL, 2'd0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({bus.busy, bus.senha_fail, bus.senha_padrao, bus.senha_master, bus.senha_master_update, bus.locked} !== 6'b0) begin
      errors++; $display("FAIL midscan_reset_flags: busy=%b fail=%b locked=%b, required 0 0 0",
                         bus.busy, bus.senha_fail, bus.locked);
    end
    checks++;
    if (bus.match_idx !== 2'd0 || bus.fail_count !== 2'd0) begin
      errors++; $display("FAIL midscan_reset_regs: match_idx=%0d fail_count=%0d, required 0 0", bus.match_idx, bus.fail_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL midscan_after_release: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_valid_high_at_reset();
    bus.master_valid = 1'b1;
    bus.master_pin = 16'h9876;
    bus.pin_digits = 16'h9876;
    rst_n = 1'b0;
    bus.pin_valid = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL held_valid_start: busy=%b, required 0", bus.busy);
    end
    bus.pin_valid = 1'b0;
    @(negedge clk);
    start_pin(16'h9876, K_MST, 2'd0, 1);
    wait_results("after_held_valid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pin_valid = 1'b0;
    bus.pin_digits = 16'hEEEE;
    bus.master_pin = 16'h0000;
    bus.master_valid = 1'b0;
    bus.user_pins = '0;
    bus.user_en = '0;
    test_reset();
    test_factory();
    test_master_and_user();
    test_invalid();
    test_ignored_edge();
    test_back_to_back();
`ifdef PIN_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    test_reset_mid_scan();
    test_valid_high_at_reset();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
